y86_stage_sequencer: RTL and testbench

//  Multi-cycle controller for the sequential Y86-64 core. Steps each instruction through

---
 rtl/y86_stage_sequencer.sv | 177 +++++++++++++++++
 tb/tb_y86_stage_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/y86_stage_sequencer.sv
// Multi-cycle stage sequencer for the sequential Y86-64 core: stage enables, PC register, dmem handshake, status.
// Optional build macro SEQ_SINGLE_STEP_EN adds a step input and a PAUSE state after each PCUPD.
module y86_stage_sequencer #(
  parameter int              PC_W        = 64,
  parameter logic [PC_W-1:0] RESET_PC    = {PC_W{1'b0}},
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic            start,
  input  logic [3:0]      icode,
  input  logic            cnd,
  input  logic            instr_valid,
  input  logic            imem_error,
  input  logic            dmem_error,
  input  logic            dmem_ack,
  input  logic [PC_W-1:0] valC,
  input  logic [PC_W-1:0] valM,
  input  logic [PC_W-1:0] valP,
  output logic            fetch_en,
  output logic            decode_en,
  output logic            exec_en,
  output logic            mem_en,
  output logic            wb_en,
  output logic            dmem_req,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      stat,
  output logic            busy
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXECUTE   = 4'd3,
    S_MEMORY    = 4'd4,
    S_WRITEBACK = 4'd5,
    S_PCUPD     = 4'd6,
    S_HALTED    = 4'd7,
    S_PAUSE     = 4'd8
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  function automatic logic is_mem_icode(input logic [3:0] ic);
    case (ic)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  state_t          state, state_next;
  logic [2:0]      stat_next;
  logic [PC_W-1:0] pc_next;
  logic [7:0]      wait_cnt, wait_next;
  logic            req_next;

  // Next-state, status, PC and memory wait-counter logic
  always_comb begin
    state_next = state;
    stat_next  = stat;
    pc_next    = pc;
    wait_next  = 8'd0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
        else       state_next = S_IDLE;
      end
      S_FETCH: begin
        if (imem_error) begin
          stat_next  = STAT_ADR;
          state_next = S_HALTED;
        end else if (!instr_valid) begin
          stat_next  = STAT_INS;
          state_next = S_HALTED;
        end else begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (icode == 4'h0) begin
          stat_next  = STAT_HLT;
          state_next = S_HALTED;
        end else begin
          state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: state_next = S_MEMORY;
      // First MEMORY cycle raises the request; ack only counts once it is visible
      S_MEMORY: begin
        if (!is_mem_icode(icode)) begin
          state_next = S_WRITEBACK;
        end else if (!dmem_req) begin
          state_next = S_MEMORY;
        end else if (dmem_ack) begin
          if (dmem_error) begin
            stat_next  = STAT_ADR;
            state_next = S_HALTED;
          end else begin
            state_next = S_WRITEBACK;
          end
        end else if (wait_cnt == TIMEOUT_CNT) begin
          stat_next  = STAT_ADR;
          state_next = S_HALTED;
        end else begin
          wait_next  = wait_cnt + 8'd1;
          state_next = S_MEMORY;
        end
      end
      S_WRITEBACK: state_next = S_PCUPD;
      S_PCUPD: begin
        case (icode)
          4'h7:    pc_next = cnd ? valC : valP;
          4'h8:    pc_next = valC;
          4'h9:    pc_next = valM;
          default: pc_next = valP;
        endcase
`ifdef SEQ_SINGLE_STEP_EN
        state_next = S_PAUSE;
`else
        state_next = S_FETCH;
`endif
      end
      S_HALTED: state_next = S_HALTED;
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (step) state_next = S_FETCH;
        else      state_next = S_PAUSE;
      end
`endif
      default: state_next = S_HALTED;
    endcase
  end

  // Request stays up only while the FSM remains in MEMORY for a memory icode
  always_comb begin
    if ((state == S_MEMORY) && (state_next == S_MEMORY) && is_mem_icode(icode)) req_next = 1'b1;
    else                                                                       req_next = 1'b0;
  end

  // State, PC, status and registered outputs decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      stat      <= STAT_AOK;
      wait_cnt  <= 8'd0;
      fetch_en  <= 1'b0;
      decode_en <= 1'b0;
      exec_en   <= 1'b0;
      mem_en    <= 1'b0;
      wb_en     <= 1'b0;
      dmem_req  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      stat      <= stat_next;
      wait_cnt  <= wait_next;
      fetch_en  <= (state_next == S_FETCH);
      decode_en <= (state_next == S_DECODE);
      exec_en   <= (state_next == S_EXECUTE);
      mem_en    <= (state_next == S_MEMORY);
      wb_en     <= (state_next == S_WRITEBACK);
      dmem_req  <= req_next;
      busy      <= !((state_next == S_IDLE) || (state_next == S_HALTED) || (state_next == S_PAUSE));
    end
  end

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// Randomized self-checking bench for y86_stage_sequencer against an instruction-level outcome model.
module tb_y86_stage_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic        cnd = 1'b0, instr_valid = 1'b1, imem_error = 1'b0, dmem_error = 1'b0, dmem_ack = 1'b0;
  logic [63:0] valC = 64'd0, valM = 64'd0, valP = 64'd0;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en, dmem_req, busy;
  logic [63:0] pc;
  logic [2:0]  stat;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] m_pc = 64'd0;
  logic [2:0]  m_stat = 3'd1;

  y86_stage_sequencer #(.PC_W(64), .RESET_PC(64'd0), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .start(start), .icode(icode), .cnd(cnd), .instr_valid(instr_valid),
    .imem_error(imem_error), .dmem_error(dmem_error), .dmem_ack(dmem_ack),
    .valC(valC), .valM(valM), .valP(valP),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .mem_en(mem_en), .wb_en(wb_en),
    .dmem_req(dmem_req), .pc(pc), .stat(stat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_pc = 64'd0;
    m_stat = 3'd1;
  endtask

  task automatic kick();
    start = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b1;
`endif
    @(negedge clk);
    start = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
  endtask

  // Run one instruction from FETCH and compare its outcome with the instruction-level model
  task automatic run_instr(input logic [3:0] ic, input logic c, input logic iv, input logic ie,
                           input logic de, input logic [63:0] vc, input logic [63:0] vm,
                           input logic [63:0] vp, input int delay, input string tag);
    bit   is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    int   e_cyc, e_req, e_mcnt;
    logic [2:0]  e_stat = 3'd1;
    logic [63:0] e_pc = m_pc;
    int   cyc = 0, reqc = 0, mcnt = 0, seq_bad = 0, pc_bad = 0, last = 0, idx;
    if (ie)            begin e_stat = 3'd3; e_cyc = 1; e_req = 0; e_mcnt = 0; end
    else if (!iv)      begin e_stat = 3'd4; e_cyc = 1; e_req = 0; e_mcnt = 0; end
    else if (ic == 0)  begin e_stat = 3'd2; e_cyc = 2; e_req = 0; e_mcnt = 0; end
    else if (is_mem && delay > 16) begin e_stat = 3'd3; e_req = 16; e_cyc = 20; e_mcnt = 17; end
    else if (is_mem && de)         begin e_stat = 3'd3; e_req = delay; e_cyc = 4 + delay; e_mcnt = 1 + delay; end
    else begin
      e_req  = is_mem ? delay : 0;
      e_cyc  = 6 + e_req;
      e_mcnt = 1 + e_req;
      if (ic == 4'h7)      e_pc = c ? vc : vp;
      else if (ic == 4'h8) e_pc = vc;
      else if (ic == 4'h9) e_pc = vm;
      else                 e_pc = vp;
    end
    icode = ic; cnd = c; instr_valid = iv; imem_error = ie; dmem_error = de;
    valC = vc; valM = vm; valP = vp;
    if (!busy) kick();
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      if (fetch_en && cyc > 0) break;
      cyc++;
      idx = fetch_en ? 1 : decode_en ? 2 : exec_en ? 3 : mem_en ? 4 : wb_en ? 5 : 6;
      if ($countones({fetch_en, decode_en, exec_en, mem_en, wb_en}) > 1 || idx < last) seq_bad++;
      last = idx;
      if (mem_en) mcnt++;
      if (pc !== m_pc) pc_bad++;
      if (dmem_req) reqc++;
      dmem_ack = dmem_req ? (reqc == delay) : 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    check_eq({tag, "/cycles"}, 64'(cyc), 64'(e_cyc));
    check_eq({tag, "/req_cycles"}, 64'(reqc), 64'(e_req));
    check_eq({tag, "/mem_cycles"}, 64'(mcnt), 64'(e_mcnt));
    check_eq({tag, "/stage_order"}, 64'(seq_bad), 64'd0);
    check_eq({tag, "/pc_stable"}, 64'(pc_bad), 64'd0);
    check_eq({tag, "/pc"}, pc, e_pc);
    check_eq({tag, "/stat"}, 64'(stat), 64'(e_stat));
`ifdef SEQ_SINGLE_STEP_EN
    check_eq({tag, "/busy"}, 64'(busy), 64'd0);
`else
    check_eq({tag, "/busy"}, 64'(busy), (e_stat == 3'd1) ? 64'd1 : 64'd0);
`endif
    m_pc = e_pc;
    m_stat = e_stat;
  endtask

  task automatic check_halt_holds(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq({tag, "/busy"}, 64'(busy), 64'd0);
    check_eq({tag, "/fetch_en"}, 64'(fetch_en), 64'd0);
    check_eq({tag, "/stat"}, 64'(stat), 64'(m_stat));
    check_eq({tag, "/pc"}, pc, m_pc);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idle_bad = 0;
    logic [3:0] ric;
    int rdelay;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if ({fetch_en, decode_en, exec_en, mem_en, wb_en, dmem_req, busy} != 7'd0 ||
          pc !== 64'd0 || stat !== 3'd1) idle_bad++;
      @(negedge clk);
    end
    check_eq("idle/violations", 64'(idle_bad), 64'd0);
    check_eq("idle/pc", pc, 64'd0);
    check_eq("idle/stat", 64'(stat), 64'd1);

    run_instr(4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h2, 1, "nop");
    run_instr(4'h7, 1'b1, 1'b1, 1'b0, 1'b0, 64'h40, 64'h0, 64'h9, 1, "jxx_taken");
    run_instr(4'h7, 1'b0, 1'b1, 1'b0, 1'b0, 64'h40, 64'h0, 64'h9, 1, "jxx_not_taken");
    run_instr(4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h123, 64'h55, 3, "ret");
    run_instr(4'h5, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h77, 1000, "mrmovq_timeout");
    check_halt_holds("timeout_halted");

    do_reset();
    run_instr(4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h50, 1, "nop2");
    run_instr(4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h51, 1, "halt");
    check_halt_holds("halt_halted");

    do_reset();
    run_instr(4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 64'h30, 1, "nop3");
    if (!busy) kick();
    reset = 1'b1;
    #1;
    check_eq("midreset/pc", pc, 64'd0);
    check_eq("midreset/stat", 64'(stat), 64'd1);
    check_eq("midreset/busy", 64'(busy), 64'd0);
    check_eq("midreset/fetch_en", 64'(fetch_en), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    m_pc = 64'd0;
    m_stat = 3'd1;

    for (int n = 0; n < 150; n++) begin
      if (m_stat != 3'd1) do_reset();
      ric = ($urandom_range(0, 19) == 0) ? 4'h0 : 4'($urandom_range(1, 11));
      rdelay = ($urandom_range(0, 7) == 0) ? 17 + int'($urandom_range(0, 5)) : int'($urandom_range(1, 6));
      run_instr(ric, 1'($urandom_range(0, 1)), ($urandom_range(0, 29) != 0), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 19) == 0), {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, rdelay, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
